// File: rtl/recep_interpreter.sv
// recep_interpreter: PS/2 scan-code interpreter feeding BCD temperature entry, status flags and a global reset pulse
module recep_interpreter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       flag,
    input  logic [7:0] DATO,
    output logic [7:0] STtemp1,
    output logic [7:0] STtemp2,
    output logic       STPeligro,
    output logic       STAlerta,
    output logic       STGas,
    output logic       Greset
);
    localparam logic [7:0] K_BREAK = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_H     = 8'h33;
    localparam logic [7:0] K_Y     = 8'h35;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_A     = 8'h1C;
    localparam logic [7:0] K_P     = 8'h4D;
    localparam logic [7:0] K_G     = 8'h34;
    localparam logic [7:0] K_R     = 8'h2D;

    logic       flag_d;
    logic       brk;
    logic       sel;
    logic [7:0] buffer;
    logic       accept;
    logic       is_digit;
    logic [3:0] digit;

    assign accept = flag & ~flag_d;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (DATO)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // The byte after F0 is the release code of a key already handled on make
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flag_d    <= 1'b1;
            brk       <= 1'b0;
            sel       <= 1'b0;
            buffer    <= 8'h00;
            STtemp1   <= 8'h00;
            STtemp2   <= 8'h00;
            STPeligro <= 1'b0;
            STAlerta  <= 1'b0;
            STGas     <= 1'b0;
            Greset    <= 1'b0;
        end else begin
            flag_d <= flag;
            Greset <= 1'b0;
            if (accept) begin
                if (brk)
                    brk <= 1'b0;
                else if (DATO == K_BREAK)
                    brk <= 1'b1;
                else if (is_digit)
                    buffer <= {buffer[3:0], digit};
                else if (DATO == K_H)
                    sel <= 1'b0;
                else if (DATO == K_Y)
                    sel <= 1'b1;
                else if (DATO == K_ENTER) begin
                    if (sel)
                        STtemp2 <= buffer;
                    else
                        STtemp1 <= buffer;
                    buffer <= 8'h00;
                end else if (DATO == K_A)
                    STAlerta <= ~STAlerta;
                else if (DATO == K_P)
                    STPeligro <= ~STPeligro;
                else if (DATO == K_G)
                    STGas <= ~STGas;
                else if (DATO == K_R) begin
                    Greset    <= 1'b1;
                    STAlerta  <= 1'b0;
                    STPeligro <= 1'b0;
                    STGas     <= 1'b0;
                    buffer    <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_recep_interpreter.sv
// tb_recep_interpreter: directed scenarios plus random key streams checked against a behavioural model
module tb_recep_interpreter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       flag = 1'b1;
    logic [7:0] DATO = 8'h2D;
    logic [7:0] STtemp1, STtemp2;
    logic       STPeligro, STAlerta, STGas, Greset;

    int errors = 0;
    int checks = 0;

    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] key_codes [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                   8'h33, 8'h35, 8'h5A, 8'h1C, 8'h4D, 8'h34, 8'h2D, 8'hF0, 8'hE0, 8'h5A};
    logic [7:0] noise_codes [3] = '{8'h33, 8'h4D, 8'h2D};

    // Model state: entered digits as a queue of the last two, target as index
    logic [7:0] m_temp [2];
    int         m_digits [$];
    int         m_sel;
    bit         m_brk, m_a, m_p, m_g, m_gr;

    recep_interpreter dut (
        .CLK(CLK), .RESET(RESET), .flag(flag), .DATO(DATO),
        .STtemp1(STtemp1), .STtemp2(STtemp2),
        .STPeligro(STPeligro), .STAlerta(STAlerta), .STGas(STGas), .Greset(Greset)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] entry_value();
        int tens = 0, units = 0;
        if (m_digits.size() == 2) begin
            tens = m_digits[0];
            units = m_digits[1];
        end else if (m_digits.size() == 1)
            units = m_digits[0];
        return 8'(tens * 16 + units);
    endfunction

    function automatic void m_reset();
        m_temp[0] = 0; m_temp[1] = 0;
        m_digits.delete();
        m_sel = 0;
        m_brk = 0; m_a = 0; m_p = 0; m_g = 0; m_gr = 0;
    endfunction

    function automatic void m_accept(input logic [7:0] c);
        int d = -1;
        for (int i = 0; i < 10; i++) if (digit_codes[i] == c) d = i;
        if (m_brk) m_brk = 0;
        else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) ;
        else if (d >= 0) begin
            m_digits.push_back(d);
            if (m_digits.size() > 2) void'(m_digits.pop_front());
        end
        else if (c == 8'h33) m_sel = 0;
        else if (c == 8'h35) m_sel = 1;
        else if (c == 8'h5A) begin
            m_temp[m_sel] = entry_value();
            m_digits.delete();
        end
        else if (c == 8'h1C) m_a = !m_a;
        else if (c == 8'h4D) m_p = !m_p;
        else if (c == 8'h34) m_g = !m_g;
        else if (c == 8'h2D) begin
            m_gr = 1; m_a = 0; m_p = 0; m_g = 0;
            m_digits.delete();
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".temp1"}, 32'(STtemp1), 32'(m_temp[0]));
        chk({tag, ".temp2"}, 32'(STtemp2), 32'(m_temp[1]));
        chk({tag, ".flags"}, 32'({STPeligro, STAlerta, STGas}), 32'({m_p, m_a, m_g}));
        chk({tag, ".greset"}, 32'(Greset), 32'(m_gr));
        m_gr = 0;
    endtask

    task automatic send(input logic [7:0] c, input int hold, input bit noise);
        @(negedge CLK); flag = 1'b1; DATO = c;
        @(posedge CLK); #1;
        m_accept(c);
        check_all("accept");
        for (int i = 1; i < hold; i++) begin
            @(negedge CLK);
            if (noise) DATO = noise_codes[$urandom_range(0, 2)];
            @(posedge CLK); #1;
            check_all("held");
        end
        @(negedge CLK); flag = 1'b0;
        @(posedge CLK); #1;
        check_all("low");
    endtask

    initial begin
        m_reset();
        // Reset with flag already high: no acceptance after release
        repeat (2) @(posedge CLK);
        #1 check_all("reset");
        @(negedge CLK); RESET = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1 check_all("post_reset_high");
        end
        @(negedge CLK); flag = 1'b0;
        @(posedge CLK); #1 check_all("post_reset_low");

        foreach (key_codes[i]) if (i < 4) ;
        send(8'h5A, 5, 0); send(8'h16, 5, 0); send(8'h3E, 5, 0); send(8'h5A, 5, 0);
        chk("t1_18", 32'(STtemp1), 32'h18);
        chk("t2_00", 32'(STtemp2), 32'h00);

        send(8'h35, 2, 0); send(8'h3D, 2, 0); send(8'h45, 2, 0); send(8'h5A, 2, 0);
        chk("t2_70", 32'(STtemp2), 32'h70);
        chk("t1_keep", 32'(STtemp1), 32'h18);
        send(8'h16, 1, 0); send(8'h1E, 1, 0); send(8'h26, 1, 0); send(8'h5A, 1, 0);
        chk("t2_23", 32'(STtemp2), 32'h23);

        send(8'h1C, 2, 0); send(8'h4D, 2, 0); send(8'h34, 2, 0);
        chk("flags_on", 32'({STPeligro, STAlerta, STGas}), 32'h7);
        send(8'h1C, 2, 0);
        chk("alerta_off", 32'(STAlerta), 32'h0);
        send(8'h2D, 3, 0);
        chk("flags_clr", 32'({STPeligro, STAlerta, STGas}), 32'h0);

        send(8'h3E, 15, 1);
        send(8'h5A, 1, 0);
        chk("held_digit", 32'(STtemp2), 32'h08);

        send(8'hF0, 2, 0); send(8'h1C, 2, 0);
        chk("break_skip", 32'(STAlerta), 32'h0);
        send(8'h1C, 2, 0);
        chk("after_break", 32'(STAlerta), 32'h1);

        // RESET coinciding with an accepting edge loses the byte
        @(negedge CLK); flag = 1'b1; DATO = 8'h1C; RESET = 1'b1;
        @(posedge CLK); #1 m_reset(); check_all("reset_collide");
        @(negedge CLK); RESET = 1'b0;
        @(posedge CLK); #1 check_all("collide_held");
        @(negedge CLK); flag = 1'b0;
        @(posedge CLK); #1 check_all("collide_low");

        for (int n = 0; n < 300; n++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 9) < 8) ? key_codes[$urandom_range(0, 19)] : 8'($urandom);
            send(c, $urandom_range(1, 4), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                @(negedge CLK); RESET = 1'b1;
                @(posedge CLK); #1 m_reset(); check_all("rand_reset");
                @(negedge CLK); RESET = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/recep_interpreter.md
Name: recep_interpreter

Overview:
- Keyboard command interpreter that sits behind the PS/2 receiver.
- Takes one 8-bit make scan code per rising edge of `flag`.
- Decodes digit keys into a two-digit BCD entry buffer and commits entries to two temperature registers.
- Decodes letter keys into three status flags and a one-cycle global-reset pulse for downstream blocks.

Parameters:
- None. Scan-code values are fixed localparams listed under Behaviour.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- flag  input  1  byte-valid from the PS/2 receiver; may stay high for many cycles.
- DATO  input  8  scan code; valid whenever flag is high.
- STtemp1  output  8  temperature 1, two BCD digits (tens in [7:4], units in [3:0]).
- STtemp2  output  8  temperature 2, same BCD format.
- STPeligro  output  1  danger status flag.
- STAlerta  output  1  alert status flag.
- STGas  output  1  gas status flag.
- Greset  output  1  one-cycle global reset pulse.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other activity. On reset:
  - STtemp1, STtemp2, the entry buffer and all 1-bit outputs go to 0.
  - The target select goes to temp1 and the break-pending bit is cleared.
  - The flag history register (flag_d) is set to 1, so a flag already high when reset is released is not accepted.
- Acceptance:
  - A byte is accepted only on the clock edge where flag=1 and flag_d=0. flag_d <= flag every cycle.
  - Exactly one byte is accepted per flag assertion. If DATO changes while flag stays high, the new byte is ignored.
- Latency: the decode and all register updates happen on the accepting edge, so outputs are visible 1 cycle after the flag rising edge.
- Break handling:
  - Accepted F0 sets break-pending and has no other effect.
  - The next accepted byte clears break-pending and is discarded.
  - Accepted E0 is ignored.
- Digit keys (0..9 = 45,16,1E,26,25,2E,36,3D,3E,46):
  - buffer <= {buffer[3:0], digit}.
  - Older digits shift out, so the buffer always holds the last two digits entered.
- Target select:
  - 33 ('H') selects temp1; 35 ('Y') selects temp2.
  - Selecting does not modify the buffer.
- Enter (5A):
  - The selected STtempN <= buffer, and buffer <= 00.
  - The target is unchanged.
- Flag keys (each press toggles its flag):
  - 1C ('A') toggles STAlerta.
  - 4D ('P') toggles STPeligro.
  - 34 ('G') toggles STGas.
- Reset key 2D ('R'):
  - Greset = 1 for exactly one cycle.
  - STAlerta, STPeligro, STGas and the buffer are cleared to 0.
  - STtemp1, STtemp2 and the target are retained.
- Greset is 0 at all other times, including during RESET.
- Any other accepted code is ignored; no state changes apart from break-pending rules.
- A RESET asserted in the same cycle as an accepting edge wins: the byte is lost and flag_d becomes 1.
- Only flag and DATO are sampled; no other handshake exists.

Test Plan:
1. Hold RESET for 2 cycles with flag=1 and DATO=2D, then release.
   -> All outputs 0. No Greset pulse until flag falls and rises again.
2. Pulse flag 5 cycles each with 5A, 16, 3E, 5A.
   -> STtemp1=8'h18 one cycle after the second 5A rising edge; buffer back to 00; STtemp2=00.
3. Pulse 35, 3D, 45, 5A.
   -> STtemp2=8'h70, STtemp1 unchanged. Then pulse 16, 1E, 26, 5A with 35 still selected.
   -> STtemp2=8'h23 (last two digits only).
4. Pulse 1C, 4D, 34.
   -> STAlerta=STPeligro=STGas=1. Pulse 1C again -> STAlerta=0. Pulse 2D -> Greset high exactly 1 cycle, all three flags 0, temps retained.
5. Accept 3E, then change DATO to 33, 4D, 2D while flag stays high for 15 cycles.
   -> Nothing changes apart from the single 3E digit entering the buffer; no Greset.
6. Pulse F0 then 1C.
   -> STAlerta unchanged. The next 1C pulse toggles it.
